conv_pool_ctrl: RTL and testbench
=================================

# conv_pool_ctrl

Frame-level scheduler for the `conv_pool` datapath. It loads the three 3x3 channel kernels and then streams one 4x4 tile address per granted cycle into the datapath. It tracks issued tiles through the datapath's fixed latency and generates the output write strobe and address for each pooled pixel. It sits between the frame/command interface and the shared image/kernel memories, and replaces free-running address counters with a start/busy/done handshake.

## Interface
Parameters:
- `PIPE_LAT`, 6: cycles from a granted `input_re` to the matching `y` being valid at the datapath output.
- `ADDR_W`, 16: width of every address port.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  frame start; accepted only in IDLE.
- `abort`  in  1  cancels the frame from any state.
- `cfg_cols`  in  8  tiles per row; sampled on accepted `start`.
- `cfg_rows`  in  8  tile rows; sampled on accepted `start`.
- `cfg_in_base`  in  ADDR_W  first tile address; sampled on accepted `start`.
- `cfg_out_base`  in  ADDR_W  first output address; sampled on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a frame completes normally.
- `kern_re`  out  1  kernel memory read.
- `kern_sel`  out  2  kernel channel: 0 = r, 1 = g, 2 = b.
- `kern_ld`  out  3  one-hot load strobe for the r/g/b kernel registers.
- `input_re`  out  1  tile read request.
- `input_addr`  out  ADDR_W  tile address.
- `in_gnt`  in  1  image memory accepts the request this cycle.
- `output_we`  out  1  pooled pixel valid.
- `output_addr`  out  ADDR_W  pooled pixel address.

## Operation
- States are IDLE, KLOAD, RUN, DRAIN and DONE; the state type is an enum.
- IDLE to KLOAD on `start`. If `cfg_cols` = 0 or `cfg_rows` = 0, go IDLE to DONE directly, with no reads and no writes.
- KLOAD lasts 3 cycles. `kern_re` = 1 and `kern_sel` = 0, 1, 2 on successive cycles. `kern_ld[k]` pulses the cycle after the read with `kern_sel` = k (1-cycle memory latency). KLOAD then goes to RUN.
- RUN: `input_re` = 1 until all tiles are issued.
  - A tile issues on a cycle with `input_re` & `in_gnt`.
  - `input_addr` is held stable while `in_gnt` = 0.
  - `input_addr` = `cfg_in_base` + row*`cfg_cols` + col, computed mod 2^ADDR_W.
  - col increments per issue and wraps to 0 at `cfg_cols`-1, at which point row increments.
  - After the issue of (row, col) = (`cfg_rows`-1, `cfg_cols`-1), `input_re` drops the next cycle and the state moves to DRAIN.
- Valid tracking uses a PIPE_LAT-deep shift register. It shifts every cycle from KLOAD onward, because the datapath is free-running, and is loaded with the issue bit. Bubbles from `in_gnt` = 0 propagate as zeros.
- `output_we` = shift register tail. `output_addr` = `cfg_out_base` + count of prior writes; it increments after each write.
- DRAIN to DONE when the shift register is all zero. DONE asserts `done` for 1 cycle, then returns to IDLE.
- `abort` in any non-IDLE state: the next state is IDLE. The shift register is cleared, so no further `output_we`. `input_re`, `kern_re` and `kern_ld` are low from the next cycle. No `done` pulse.
- `abort` takes priority over `start` in the same cycle.
- `start` while `busy` is ignored; the config registers are not resampled.

## Timing
- Reset values: all outputs 0, addresses 0, state IDLE, shift register cleared.
- All outputs are registered.
- `busy` rises the cycle after the accepted `start`.
- First `kern_re` is the cycle after `start`. First `input_re` is 3 cycles later.
- A grant in cycle t produces `output_we` in cycle t+PIPE_LAT.
- Throughput is 1 tile/cycle with `in_gnt` held high.
- `done` follows the last `output_we` by 1 cycle. `busy` falls with `done` low.
- Reset asserted mid-frame takes effect immediately and asynchronously, giving the reset values.

## Structure
- `conv_pool_pkg` holds the state enum, the PIPE_LAT default, the KSEL_R/G/B constants and the tile counter width (8).
- Sub-module `conv_pool_valid_pipe` is the parameterized shift register:
  - inputs: `clk`, `rst`, `clr`, `in`;
  - outputs: `out` and `any`, where `any` = OR of all stages, used for the DRAIN exit.
- The top level holds the FSM, the tile counters, the address math and the output counter.

## Test plan
- 2x2 frame, in_base 0x100, out_base 0x20, `in_gnt` = 1:
  - `kern_sel` 0, 1, 2 on consecutive cycles with `kern_ld` 001, 010, 100 one cycle later;
  - `input_addr` 0x100–0x103 consecutive;
  - `output_we` for 4 cycles starting 6 cycles after the first grant, `output_addr` 0x20–0x23;
  - `done` 1 cycle after the last write.
- 3x1 frame with `in_gnt` toggling 1,0,0,1,1: `input_addr` is held during the low cycles. `output_we` reproduces the same bubble pattern delayed by PIPE_LAT. 3 writes total.
- `cfg_cols` = 0: `start` is followed by `busy` for 1 cycle, `done` pulses, and there is no `kern_re`, `input_re` or `output_we`.
- Abort at the 5th grant of a 4x4 frame: `input_re` is low the next cycle, no `output_we` after the abort cycle, no `done`, IDLE. A new `start` then runs a full frame correctly.
- `start` pulsed during RUN with different config: ignored; addresses continue from the original config.
- `rst` low mid-DRAIN: all outputs are 0 immediately; the frame after reset behaves as in the first test.

Source files
------------

// File: rtl/conv_pool_pkg.sv
// Shared types and constants for the conv_pool frame scheduler.
// Provides the FSM state enum, kernel channel selects and the tile counter width.
package conv_pool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KLOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int PIPE_LAT_DEF = 6;
    localparam int TILE_CNT_W   = 8;

    localparam logic [1:0] KSEL_R = 2'd0;
    localparam logic [1:0] KSEL_G = 2'd1;
    localparam logic [1:0] KSEL_B = 2'd2;

    function automatic logic [2:0] ksel_onehot(input logic [1:0] sel);
        return 3'b001 << sel;
    endfunction

endpackage

// File: rtl/conv_pool_valid_pipe.sv
// Valid-bit shift register that mirrors the free-running datapath latency.
// 'any' reports whether a tile is still in flight anywhere in the pipe.
module conv_pool_valid_pipe
    import conv_pool_pkg::*;
#(
    parameter int DEPTH = PIPE_LAT_DEF - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in,
    output logic out,
    output logic any
);

    logic [DEPTH-1:0] r_stage;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage <= '0;
        end else if (clr) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= in;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign out = r_stage[DEPTH-1];
    assign any = |r_stage;

endmodule

// File: rtl/conv_pool_ctrl.sv
// Frame scheduler: kernel load, tile issue under memory grant, output write tracking.
// Valid/ready: a tile transfers on any cycle where input_re and in_gnt are both high.
module conv_pool_ctrl
    import conv_pool_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        cfg_cols,
    input  logic [7:0]        cfg_rows,
    input  logic [ADDR_W-1:0] cfg_in_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    output logic              busy,
    output logic              done,
    output logic              kern_re,
    output logic [1:0]        kern_sel,
    output logic [2:0]        kern_ld,
    output logic              input_re,
    output logic [ADDR_W-1:0] input_addr,
    input  logic              in_gnt,
    output logic              output_we,
    output logic [ADDR_W-1:0] output_addr,
    output state_t            dbg_state
);

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_kcnt;
    logic [2:0]            r_kern_ld;
    logic [TILE_CNT_W-1:0] r_cols;
    logic [TILE_CNT_W-1:0] r_rows;
    logic [TILE_CNT_W-1:0] r_col;
    logic [TILE_CNT_W-1:0] r_row;
    logic [ADDR_W-1:0]     r_in_addr;
    logic [ADDR_W-1:0]     r_out_addr;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_kern_re;
    logic                  r_input_re;
    logic                  r_output_we;
    logic                  w_accept;
    logic                  w_abort;
    logic                  w_issue;
    logic                  w_last;
    logic                  w_pipe_out;
    logic                  w_pipe_any;

    assign w_accept = (r_state == ST_IDLE) && start && !abort;
    assign w_abort  = (r_state != ST_IDLE) && abort;
    assign w_issue  = r_input_re && in_gnt;
    assign w_last   = (r_row == r_rows - TILE_CNT_W'(1)) && (r_col == r_cols - TILE_CNT_W'(1));

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = (cfg_cols == 8'd0 || cfg_rows == 8'd0) ? ST_DONE : ST_KLOAD;
            ST_KLOAD: if (r_kcnt == KSEL_B) w_next_state = ST_RUN;
            ST_RUN:   if (w_issue && w_last) w_next_state = ST_DRAIN;
            ST_DRAIN: if (!w_pipe_any) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
        if (w_abort) w_next_state = ST_IDLE;
    end

    // Control outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_kern_re   <= 1'b0;
            r_input_re  <= 1'b0;
            r_kcnt      <= 2'd0;
            r_kern_ld   <= 3'b000;
            r_output_we <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= (w_next_state == ST_DONE);
            r_kern_re   <= (w_next_state == ST_KLOAD);
            r_input_re  <= (w_next_state == ST_RUN);
            r_kcnt      <= (r_state == ST_KLOAD && w_next_state == ST_KLOAD) ? r_kcnt + 2'd1 : 2'd0;
            r_kern_ld   <= (r_kern_re && !w_abort) ? ksel_onehot(r_kcnt) : 3'b000;
            r_output_we <= w_pipe_out && !w_abort;
        end
    end

    // Tiles are issued in raster order, so base + row*cols + col is a running increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cols     <= '0;
            r_rows     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_in_addr  <= '0;
            r_out_addr <= '0;
        end else if (w_accept) begin
            r_cols     <= cfg_cols;
            r_rows     <= cfg_rows;
            r_col      <= '0;
            r_row      <= '0;
            r_in_addr  <= cfg_in_base;
            r_out_addr <= cfg_out_base;
        end else begin
            if (w_issue && !w_abort) begin
                r_in_addr <= r_in_addr + ADDR_W'(1);
                if (r_col == r_cols - TILE_CNT_W'(1)) begin
                    r_col <= '0;
                    r_row <= r_row + TILE_CNT_W'(1);
                end else begin
                    r_col <= r_col + TILE_CNT_W'(1);
                end
            end
            if (r_output_we) r_out_addr <= r_out_addr + ADDR_W'(1);
        end
    end

    // The registered output_we is the final valid stage, so the pipe holds PIPE_LAT-1 stages.
    conv_pool_valid_pipe #(
        .DEPTH (PIPE_LAT - 1)
    ) u_valid_pipe (
        .clk (clk),
        .rst (rst),
        .clr (w_abort),
        .in  (w_issue && !w_abort),
        .out (w_pipe_out),
        .any (w_pipe_any)
    );

    assign busy        = r_busy;
    assign done        = r_done;
    assign kern_re     = r_kern_re;
    assign kern_sel    = r_kcnt;
    assign kern_ld     = r_kern_ld;
    assign input_re    = r_input_re;
    assign input_addr  = r_in_addr;
    assign output_we   = r_output_we;
    assign output_addr = r_out_addr;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_conv_pool_ctrl.sv
// Scoreboard bench for conv_pool_ctrl: drivers queue timed expectations, a negedge monitor pops them.
// Each queue entry is {cycle, value}, so both timing and data are compared on every event.
module tb_conv_pool_ctrl;
    import conv_pool_pkg::*;

    localparam int ADDR_W = 16;
    localparam int LAT    = 6;
    localparam int EW     = 48;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              in_gnt = 1'b0;
    logic [7:0]        cfg_cols = '0;
    logic [7:0]        cfg_rows = '0;
    logic [ADDR_W-1:0] cfg_in_base = '0;
    logic [ADDR_W-1:0] cfg_out_base = '0;
    logic              busy, done, kern_re, input_re, output_we;
    logic [1:0]        kern_sel;
    logic [2:0]        kern_ld;
    logic [ADDR_W-1:0] input_addr, output_addr;
    state_t            dbg_state;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_kern_q[$];
    logic [EW-1:0] exp_ld_q[$];
    logic [EW-1:0] exp_in_q[$];
    logic [EW-1:0] exp_wr_q[$];
    logic [EW-1:0] exp_done_q[$];

    conv_pool_ctrl #(.PIPE_LAT(LAT), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_cols     (cfg_cols),
        .cfg_rows     (cfg_rows),
        .cfg_in_base  (cfg_in_base),
        .cfg_out_base (cfg_out_base),
        .busy         (busy),
        .done         (done),
        .kern_re      (kern_re),
        .kern_sel     (kern_sel),
        .kern_ld      (kern_ld),
        .input_re     (input_re),
        .input_addr   (input_addr),
        .in_gnt       (in_gnt),
        .output_we    (output_we),
        .output_addr  (output_addr),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle index
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic ev_chk(input string name, input logic [EW-1:0] e, input logic [15:0] v);
        n_tests++;
        if (e !== {32'(cyc), v}) begin
            n_fail++;
            $display("FAIL %s: got value 0x%0h at cycle %0d, expected value 0x%0h at cycle %0d",
                     name, v, cyc, e[15:0], e[47:16]);
        end
    endtask

    task automatic unexpected(input string name, input logic [15:0] v);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event value 0x%0h at cycle %0d, expected none", name, v, cyc);
    endtask

    function automatic bit pat_bit(input logic [31:0] pat, input int plen, input int i);
        return (i < plen) ? pat[i] : 1'b1;
    endfunction

    // Monitor: every output event must match the head of its queue in cycle and value
    always @(negedge clk) begin
        if (rst) begin
            if (kern_re) begin
                if (exp_kern_q.size() == 0) unexpected("kern_rd", 16'(kern_sel));
                else ev_chk("kern_rd", exp_kern_q.pop_front(), 16'(kern_sel));
            end
            if (kern_ld != 3'b000) begin
                if (exp_ld_q.size() == 0) unexpected("kern_ld", 16'(kern_ld));
                else ev_chk("kern_ld", exp_ld_q.pop_front(), 16'(kern_ld));
            end
            if (input_re) begin
                if (exp_in_q.size() == 0) unexpected("input_rd", input_addr);
                else if (in_gnt) ev_chk("input_rd", exp_in_q.pop_front(), input_addr);
                else chk("input_hold", 64'(input_addr), 64'(exp_in_q[0][15:0]));
            end
            if (output_we) begin
                if (exp_wr_q.size() == 0) unexpected("output_wr", output_addr);
                else ev_chk("output_wr", exp_wr_q.pop_front(), output_addr);
            end
            if (done) begin
                if (exp_done_q.size() == 0) unexpected("done", 16'd1);
                else ev_chk("done", exp_done_q.pop_front(), 16'd1);
            end
        end
    end

    task automatic flush();
        exp_kern_q.delete();
        exp_ld_q.delete();
        exp_in_q.delete();
        exp_wr_q.delete();
        exp_done_q.delete();
    endtask

    // Driver: push the whole frame's expectations, then issue start and grants
    task automatic run_frame(input int cols, input int rows, input logic [15:0] in_base,
                             input logic [15:0] out_base, input logic [31:0] pat, input int plen,
                             input int abort_k, input bit restart, input bit rst_drain);
        int s, n, i, issued, limit, abort_cyc;
        int gcyc[$];
        s = cyc;
        n = cols * rows;
        abort_cyc = 32'h7fff_ffff;
        limit = (abort_k > 0) ? abort_k : n;
        if (n == 0) begin
            exp_done_q.push_back({32'(s + 1), 16'd1});
        end else begin
            for (int k = 0; k < 3; k++) begin
                exp_kern_q.push_back({32'(s + 1 + k), 16'(k)});
                exp_ld_q.push_back({32'(s + 2 + k), 16'(1 << k)});
            end
            i = 0;
            while (gcyc.size() < limit) begin
                if (pat_bit(pat, plen, i)) gcyc.push_back(s + 4 + i);
                i++;
            end
            if (abort_k > 0) abort_cyc = gcyc[abort_k - 1];
            for (int j = 0; j < limit; j++) begin
                exp_in_q.push_back({32'(gcyc[j]), 16'(in_base + 16'(j))});
                if (gcyc[j] + LAT <= abort_cyc)
                    exp_wr_q.push_back({32'(gcyc[j] + LAT), 16'(out_base + 16'(j))});
            end
            if (abort_k == 0 && !rst_drain)
                exp_done_q.push_back({32'(gcyc[n - 1] + LAT + 1), 16'd1});
        end

        start = 1'b1;
        cfg_cols = 8'(cols);
        cfg_rows = 8'(rows);
        cfg_in_base = in_base;
        cfg_out_base = out_base;
        step();
        start = 1'b0;
        cfg_cols = 8'($urandom_range(1, 255));
        cfg_rows = 8'($urandom_range(1, 255));
        cfg_in_base = 16'($urandom_range(0, 65535));
        cfg_out_base = 16'($urandom_range(0, 65535));
        chk("busy_rise", 64'(busy), 64'd1);

        if (n == 0) begin
            step();
            chk("zero_busy_fall", 64'(busy), 64'd0);
            return;
        end

        while (cyc < s + 4) step();
        i = 0;
        issued = 0;
        while (issued < limit) begin
            in_gnt = pat_bit(pat, plen, i);
            if (in_gnt) issued++;
            if (abort_k > 0 && issued == abort_k) abort = 1'b1;
            if (restart && i == 2) begin
                start = 1'b1;
                cfg_cols = 8'($urandom_range(1, 255));
                cfg_rows = 8'($urandom_range(1, 255));
                cfg_in_base = 16'($urandom_range(0, 65535));
                cfg_out_base = 16'($urandom_range(0, 65535));
            end
            step();
            in_gnt = 1'b0;
            abort = 1'b0;
            start = 1'b0;
            i++;
        end

        if (abort_k > 0) begin
            chk("abort_input_re", 64'(input_re), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_state", 64'(dbg_state), 64'(ST_IDLE));
            repeat (12) step();
            return;
        end

        if (rst_drain) begin
            step();
            step();
            rst = 1'b0;
            #1;
            chk("rst_drain_outs", {busy, done, kern_re, kern_sel, kern_ld, input_re, input_addr,
                                   output_we, output_addr}, 64'd0);
            chk("rst_drain_state", 64'(dbg_state), 64'(ST_IDLE));
            flush();
            step();
            step();
            rst = 1'b1;
            step();
            return;
        end

        for (int t = 0; t < 60 && exp_done_q.size() != 0; t++) step();
        if (exp_done_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: done not seen, %0d writes still pending", exp_wr_q.size());
            flush();
        end else begin
            chk("busy_fall", 64'(busy), 64'd0);
            chk("done_low", 64'(done), 64'd0);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        step();
        step();
        chk("reset_outs", {busy, done, kern_re, kern_sel, kern_ld, input_re, input_addr,
                           output_we, output_addr}, 64'd0);
        chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b1;
        step();

        run_frame(2, 2, 16'h0100, 16'h0020, 32'h0, 0, 0, 1'b0, 1'b0);
        run_frame(3, 1, 16'h0200, 16'h0040, 32'b11001, 5, 0, 1'b0, 1'b0);
        run_frame(0, 5, 16'h0300, 16'h0050, 32'h0, 0, 0, 1'b0, 1'b0);
        run_frame(4, 0, 16'h0300, 16'h0050, 32'h0, 0, 0, 1'b0, 1'b0);
        run_frame(4, 4, 16'h0300, 16'h0060, 32'h0, 0, 5, 1'b0, 1'b0);
        run_frame(4, 4, 16'h0300, 16'h0060, 32'h0, 0, 0, 1'b0, 1'b0);
        run_frame(3, 3, 16'h0400, 16'h0080, 32'h0, 0, 0, 1'b1, 1'b0);
        run_frame(2, 2, 16'hfffe, 16'hffff, 32'b0110, 4, 0, 1'b0, 1'b0);
        run_frame(2, 2, 16'h0100, 16'h0020, 32'h0, 0, 0, 1'b0, 1'b1);
        run_frame(2, 2, 16'h0100, 16'h0020, 32'h0, 0, 0, 1'b0, 1'b0);

        repeat (4) step();
        chk("queues_empty", 64'(exp_kern_q.size() + exp_ld_q.size() + exp_in_q.size()
                                + exp_wr_q.size() + exp_done_q.size()), 64'd0);
        chk("final_idle", 64'(dbg_state), 64'(ST_IDLE));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
